// File: rtl/sim_mon_pkg.sv
// Shared types and helpers for the simulation completion monitor.
package sim_mon_pkg;

  typedef enum logic [1:0] {HOLD, RUN, PASS, FAIL} state_e;

  typedef enum logic [1:0] {R_NONE, R_TIMEOUT, R_CHFAIL, R_STALL} reason_e;

  // Index of the lowest set bit; 0 when no bit is set.
  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    lowest_set = '0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i]) lowest_set = 5'(i);
    end
  endfunction

endpackage

// File: rtl/sim_mon_stall_ctr.sv
// Per-channel idle-progress counter; flags a channel that stays silent for
// STALL_CYCLES consecutive RUN cycles. Built only with SIM_MON_STALL_DETECT_EN.
module sim_mon_stall_ctr
  import sim_mon_pkg::*;
#(
  parameter int STALL_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic i_run,
  input  logic i_clear,
  output logic o_stalled
);

  localparam int SW = $clog2(STALL_CYCLES + 1);

  logic [SW-1:0] r_cnt;

  // Saturates at the limit so the stall flag stays up until cleared.
  always_ff @(posedge clock) begin
    if (!reset) r_cnt <= '0;
    else if (!i_run || i_clear) r_cnt <= '0;
    else if (r_cnt != SW'(STALL_CYCLES)) r_cnt <= r_cnt + 1'b1;
  end

  assign o_stalled = (r_cnt == SW'(STALL_CYCLES));

endmodule

// File: rtl/sim_completion_monitor.sv
// Harness end-of-sim monitor: reset sequencing, cycle counting, multi-channel
// verdict, timeout and dump gating. Optional stall detection: SIM_MON_STALL_DETECT_EN.
module sim_completion_monitor
  import sim_mon_pkg::*;
#(
  parameter int NUM_CH       = 4,
  parameter int CYC_W        = 64,
  parameter int RESET_CYCLES = 16,
  parameter int STALL_CYCLES = 4096,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [CYC_W-1:0]  max_cycles,
  input  logic [CYC_W-1:0]  dump_start,
  input  logic [NUM_CH-1:0] ch_success,
  input  logic [NUM_CH-1:0] ch_fail,
  input  logic [NUM_CH-1:0] ch_progress,
  output logic              dut_reset,
  output logic [CYC_W-1:0]  cycle_count,
  output logic              dump_en,
  output logic              done,
  output logic              pass,
  output logic              fail,
  output logic [1:0]        fail_reason,
  output logic [CH_W-1:0]   fail_channel
);

  state_e            r_state, w_state_nxt;
  reason_e           r_reason, w_reason_nxt;
  logic [CH_W-1:0]   r_fch, w_fch_nxt;
  logic [NUM_CH-1:0] r_mask, w_mask_nxt;
  logic [CYC_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_dump, w_dump_nxt;
  logic [NUM_CH-1:0] w_stall;
  logic              w_run;

  assign w_run = (r_state == RUN);

`ifdef SIM_MON_STALL_DETECT_EN
  logic [NUM_CH-1:0] w_stalled;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_stall
    sim_mon_stall_ctr #(.STALL_CYCLES(STALL_CYCLES)) u_ctr (
      .clock    (clock),
      .reset    (reset),
      .i_run    (w_run),
      .i_clear  (ch_progress[g] | ch_success[g]),
      .o_stalled(w_stalled[g])
    );
  end

  // Channels that already reported success are exempt.
  assign w_stall = w_stalled & ~r_mask;
`else
  logic w_unused_progress;
  assign w_unused_progress = ^ch_progress;
  assign w_stall           = '0;
`endif

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state  <= HOLD;
      r_reason <= R_NONE;
      r_fch    <= '0;
      r_mask   <= '0;
      r_cnt    <= '0;
      r_dump   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_reason <= w_reason_nxt;
      r_fch    <= w_fch_nxt;
      r_mask   <= w_mask_nxt;
      r_cnt    <= w_cnt_nxt;
      r_dump   <= w_dump_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_reason_nxt = r_reason;
    w_fch_nxt    = r_fch;
    w_mask_nxt   = r_mask;
    w_cnt_nxt    = r_cnt;
    w_dump_nxt   = r_dump;

    // Counter runs in HOLD/RUN, saturates, and freezes on a verdict.
    if ((r_state == HOLD || r_state == RUN) && r_cnt != '1)
      w_cnt_nxt = r_cnt + 1'b1;

    case (r_state)
      HOLD: begin
        if (r_cnt == CYC_W'(RESET_CYCLES)) w_state_nxt = RUN;
      end
      RUN: begin
        w_mask_nxt = r_mask | ch_success;
        if (|ch_fail) begin
          w_state_nxt  = FAIL;
          w_reason_nxt = R_CHFAIL;
          w_fch_nxt    = CH_W'(lowest_set(32'(ch_fail)));
        end else if (|w_stall) begin
          w_state_nxt  = FAIL;
          w_reason_nxt = R_STALL;
          w_fch_nxt    = CH_W'(lowest_set(32'(w_stall)));
        end else if (max_cycles != '0 && r_cnt > max_cycles) begin
          w_state_nxt  = FAIL;
          w_reason_nxt = R_TIMEOUT;
        end else if (w_mask_nxt == '1) begin
          w_state_nxt  = PASS;
        end
      end
      default: ;
    endcase

    // Dump window opens one cycle into RUN or when the count hits dump_start;
    // it is sticky until the verdict, so a missed match point never opens it.
    if (w_state_nxt == RUN) begin
      if (dump_start == '0) begin
        if (r_state == RUN) w_dump_nxt = 1'b1;
      end else if (w_cnt_nxt == dump_start) begin
        w_dump_nxt = 1'b1;
      end
    end else begin
      w_dump_nxt = 1'b0;
    end
  end

  assign dut_reset    = (r_state == HOLD);
  assign cycle_count  = r_cnt;
  assign dump_en      = r_dump;
  assign done         = (r_state == PASS) || (r_state == FAIL);
  assign pass         = (r_state == PASS);
  assign fail         = (r_state == FAIL);
  assign fail_reason  = r_reason;
  assign fail_channel = r_fch;

endmodule

// File: tb/tb_sim_completion_monitor.sv
// Scoreboard bench for sim_completion_monitor: expected verdicts are queued
// as stimulus is driven and popped when done rises.
module tb_sim_completion_monitor;

  localparam int NUM_CH = 4;
  localparam int CYC_W  = 64;
  localparam int RST_C  = 16;
  localparam int STALL  = 8;

  logic              clock;
  logic              reset;
  logic [CYC_W-1:0]  max_cycles;
  logic [CYC_W-1:0]  dump_start;
  logic [NUM_CH-1:0] ch_success;
  logic [NUM_CH-1:0] ch_fail;
  logic [NUM_CH-1:0] ch_progress;
  logic              dut_reset;
  logic [CYC_W-1:0]  cycle_count;
  logic              dump_en;
  logic              done;
  logic              pass;
  logic              fail;
  logic [1:0]        fail_reason;
  logic [1:0]        fail_channel;

  typedef struct {
    logic        pass;
    logic        fail;
    logic [1:0]  reason;
    logic [1:0]  ch;
    logic [63:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;
  int   cyc   = 0;

  sim_completion_monitor #(
    .NUM_CH(NUM_CH), .CYC_W(CYC_W), .RESET_CYCLES(RST_C), .STALL_CYCLES(STALL)
  ) dut (
    .clock(clock), .reset(reset), .max_cycles(max_cycles), .dump_start(dump_start),
    .ch_success(ch_success), .ch_fail(ch_fail), .ch_progress(ch_progress),
    .dut_reset(dut_reset), .cycle_count(cycle_count), .dump_en(dump_en),
    .done(done), .pass(pass), .fail(fail), .fail_reason(fail_reason),
    .fail_channel(fail_channel)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic advance(input int target);
    while (cyc < target) tick();
  endtask

  task automatic push(input logic p, input logic f, input logic [1:0] r,
                      input logic [1:0] c, input logic [63:0] n);
    exp_t e;
    e.pass = p; e.fail = f; e.reason = r; e.ch = c; e.cnt = n;
    q.push_back(e);
  endtask

  task automatic do_reset(input logic [63:0] mc, input logic [63:0] ds);
    reset       = 1'b0;
    ch_success  = '0;
    ch_fail     = '0;
    ch_progress = '1;
    max_cycles  = mc;
    dump_start  = ds;
    tick();
    tick();
    chk("rst_dut_reset", dut_reset, 1);
    chk("rst_count", cycle_count, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_fail", fail, 0);
    chk("rst_reason", fail_reason, 0);
    chk("rst_channel", fail_channel, 0);
    chk("rst_dump", dump_en, 0);
    reset = 1'b1;
    cyc   = 0;
  endtask

  task automatic wait_done(input int bound);
    exp_t e;
    int   n = 0;
    while (!done && n < bound) begin
      tick();
      n++;
    end
    chk("done_seen", done, 1);
    chk("sb_size", q.size(), 1);
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("v_pass", pass, e.pass);
      chk("v_fail", fail, e.fail);
      chk("v_reason", fail_reason, e.reason);
      chk("v_channel", fail_channel, e.ch);
      chk("v_count", cycle_count, e.cnt);
      chk("v_dump_off", dump_en, 0);
      chk("v_dut_reset", dut_reset, 0);
    end
  endtask

  initial begin
    reset = 1'b0;

    // Reset sequencing, dump from RUN+1, split success -> pass at 41
    do_reset(0, 0);
    for (int c = 1; c <= 17; c++) begin
      tick();
      chk("seq_count", cycle_count, 64'(c));
      chk("seq_dut_reset", dut_reset, (c <= RST_C) ? 64'd1 : 64'd0);
      chk("seq_dump", dump_en, 0);
    end
    tick();
    chk("dump_run1", dump_en, 1);
    advance(30);
    ch_success = 4'b0101;
    tick();
    ch_success = '0;
    advance(40);
    chk("no_early_pass", done, 0);
    ch_success = 4'b1010;
    push(1, 0, 2'd0, 2'd0, 64'd41);
    tick();
    ch_success = '0;
    wait_done(50);
    ch_fail = 4'b1111;
    for (int i = 0; i < 3; i++) tick();
    chk("count_frozen", cycle_count, 41);
    chk("pass_sticky", pass, 1);
    chk("fail_ignored", fail, 0);

    // Timeout at max_cycles=100; dump_start behind the count never opens
    do_reset(100, 10);
    advance(50);
    chk("dump_missed", dump_en, 0);
    push(0, 1, 2'd1, 2'd0, 64'd102);
    wait_done(200);

    // Fail together with the final success -> channel fail wins
    do_reset(0, 0);
    advance(20);
    ch_success = 4'b1011;
    tick();
    ch_success = '0;
    advance(25);
    ch_success = 4'b0100;
    ch_fail    = 4'b0100;
    push(0, 1, 2'd2, 2'd2, 64'd26);
    tick();
    ch_success = '0;
    ch_fail    = '0;
    wait_done(20);

    // dump_start=50, then lowest of two failing channels
    do_reset(0, 50);
    advance(49);
    chk("dump_pre50", dump_en, 0);
    tick();
    chk("dump_at50", dump_en, 1);
    advance(60);
    chk("dump_hold", dump_en, 1);
    ch_fail = 4'b1010;
    push(0, 1, 2'd2, 2'd1, 64'd61);
    tick();
    ch_fail = '0;
    wait_done(20);

    // Fail outranks a timeout that is also due
    do_reset(18, 0);
    advance(19);
    ch_fail = 4'b1000;
    push(0, 1, 2'd2, 2'd3, 64'd20);
    tick();
    ch_fail = '0;
    wait_done(20);

    // Reset mid-RUN clears everything, including the success mask
    do_reset(0, 0);
    advance(25);
    ch_success = 4'b0001;
    tick();
    ch_success = '0;
    advance(35);
    chk("mid_dump_on", dump_en, 1);
    do_reset(0, 0);
    advance(20);
    ch_success = 4'b1110;
    tick();
    ch_success = '0;
    advance(28);
    chk("mask_cleared", done, 0);
    ch_success = 4'b0001;
    push(1, 0, 2'd0, 2'd0, 64'd29);
    tick();
    ch_success = '0;
    wait_done(20);

`ifdef SIM_MON_STALL_DETECT_EN
    // ch1 silent -> stall after STALL idle RUN cycles
    do_reset(0, 0);
    ch_progress = 4'b1101;
    push(0, 1, 2'd3, 2'd1, 64'(RST_C + 1 + STALL + 1));
    wait_done(100);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
